div_rem_seq: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU in the execute stage.
- The core asserts a start request, stalls on o_busy, and captures the result on o_done.
- Each step is a trial subtraction plus a borrow test: the sequential, consuming counterpart of the signed/unsigned less-than path.

---
 rtl/div_pkg.sv | 46 ++++
 rtl/add_sub_32_bit.sv | 28 ++
 rtl/div_rem_seq.sv | 189 ++++++++++++++++++
 tb/tb_div_rem_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the iterative RV32M divider (div_rem_seq).
//
// Configuration macro: DIV_SPECIAL_FASTPATH_EN
//   When defined, the state encoding gains ST_SPECIAL, which lets
//   divide-by-zero and signed overflow finish without iterating.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int          ITER       = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // op[0] = unsigned, op[1] = remainder
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

`ifdef DIV_SPECIAL_FASTPATH_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPECIAL = 3'd1,
        ST_CALC    = 3'd2,
        ST_FIX     = 3'd3,
        ST_DONE    = 3'd4
    } div_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd2,
        ST_FIX     = 3'd3,
        ST_DONE    = 3'd4
    } div_state_e;
`endif

    // Two's complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] abs_if_signed(input logic [31:0] x,
                                                  input logic        is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/add_sub_32_bit.sv
// -----------------------------------------------------------------------------
// add_sub_32_bit
// 32-bit ripple-style adder/subtractor.
//   Sel = 0 : Result = A + B
//   Sel = 1 : Result = A - B (A + ~B + 1)
// Ports:
//   A, B   : 32-bit operands
//   Sel    : 0 add, 1 subtract
//   Result : 32-bit sum/difference
//   Cout   : carry out; when subtracting, 1 means no borrow (A >= B)
// -----------------------------------------------------------------------------
module add_sub_32_bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Sel,
    output logic [31:0] Result,
    output logic        Cout
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    assign b_eff  = B ^ {32{Sel}};
    assign sum    = {1'b0, A} + {1'b0, b_eff} + {32'd0, Sel};
    assign Result = sum[31:0];
    assign Cout   = sum[32];

endmodule

// File: rtl/div_rem_seq.sv
// -----------------------------------------------------------------------------
// div_rem_seq
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; the core raises i_start, stalls on o_busy and
// captures o_result while o_done is high.
//
// Ports:
//   i_clk     : rising-edge clock
//   i_reset   : asynchronous active-high reset (aborts any operation)
//   i_start   : request, only sampled in IDLE
//   i_op      : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a, i_b  : dividend / divisor, latched on the accepting edge
//   o_busy    : high from the cycle after acceptance through DONE
//   o_done    : one-cycle pulse, o_result valid
//   o_result  : quotient or remainder, held until the next accepted start
//
// Configuration macro: DIV_SPECIAL_FASTPATH_EN
//   Defined   : x/0 and INT_MIN/-1 go through ST_SPECIAL, done 2 cycles after
//               acceptance.
//   Undefined : those cases iterate like any other; FIX substitutes the
//               special value, done 34 cycles after acceptance.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for i_start
// ST_SPECIAL | load x/0 or overflow result (fast-path build only)
// ST_CALC    | 32 shift/trial-subtract iterations
// ST_FIX     | apply sign correction (or special value) into o_result
// ST_DONE    | o_done pulse
// -----------------------------------------------------------------------------
module div_rem_seq
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    div_state_e  state_q, state_d;
    div_op_e     op_q, op_d;
    logic [31:0] b_abs_q, b_abs_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [4:0]  count_q, count_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        special_q, special_d;
    logic [31:0] special_val_q, special_val_d;
    logic [31:0] result_q, result_d;

    logic        in_signed;
    logic        in_div_zero;
    logic        in_overflow;
    logic [31:0] r_sh;
    logic [31:0] trial;
    logic        trial_cout;
    logic        no_borrow;

    assign in_signed   = ~i_op[0];
    assign in_div_zero = (i_b == 32'd0);
    assign in_overflow = in_signed && (i_a == INT_MIN) && (i_b == 32'hFFFF_FFFF);

    // Shift {R,Q} left by one; the bit leaving R is handled by no_borrow.
    assign r_sh = {r_q[30:0], q_q[31]};

    add_sub_32_bit u_trial_sub (
        .A      (r_sh),
        .B      (b_abs_q),
        .Sel    (1'b1),
        .Result (trial),
        .Cout   (trial_cout)
    );

    // If R's MSB is shifted out, the true shifted remainder is >= 2^32 and
    // therefore exceeds any divisor; the 32-bit difference is still exact
    // because the real result is below |b|.
    assign no_borrow = trial_cout | r_q[31];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        b_abs_d       = b_abs_q;
        r_d           = r_q;
        q_d           = q_q;
        count_d       = count_q;
        quot_neg_d    = quot_neg_q;
        rem_neg_d     = rem_neg_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        result_d      = result_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    op_d          = div_op_e'(i_op);
                    b_abs_d       = abs_if_signed(i_b, in_signed);
                    q_d           = abs_if_signed(i_a, in_signed);
                    r_d           = 32'd0;
                    count_d       = 5'(ITER - 1);
                    quot_neg_d    = in_signed && (i_a[31] ^ i_b[31]) && !in_div_zero;
                    rem_neg_d     = in_signed && i_a[31];
                    special_d     = in_div_zero || in_overflow;
                    if (in_div_zero) begin
                        special_val_d = i_op[1] ? i_a : DIV_ZERO_Q;
                    end else begin
                        special_val_d = i_op[1] ? 32'd0 : INT_MIN;
                    end
`ifdef DIV_SPECIAL_FASTPATH_EN
                    state_d = (in_div_zero || in_overflow) ? ST_SPECIAL : ST_CALC;
`else
                    state_d = ST_CALC;
`endif
                end
            end
`ifdef DIV_SPECIAL_FASTPATH_EN
            ST_SPECIAL: begin
                result_d = special_val_q;
                state_d  = ST_DONE;
            end
`endif
            ST_CALC: begin
                r_d = no_borrow ? trial : r_sh;
                q_d = {q_q[30:0], no_borrow};
                if (count_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            ST_FIX: begin
                if (special_q) begin
                    result_d = special_val_q;
                end else if (op_q[1]) begin
                    result_d = rem_neg_q ? (~r_q + 32'd1) : r_q;
                end else begin
                    result_d = quot_neg_q ? (~q_q + 32'd1) : q_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            op_q          <= DIV;
            b_abs_q       <= '0;
            r_q           <= '0;
            q_q           <= '0;
            count_q       <= '0;
            quot_neg_q    <= 1'b0;
            rem_neg_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            b_abs_q       <= b_abs_d;
            r_q           <= r_d;
            q_q           <= q_d;
            count_q       <= count_d;
            quot_neg_q    <= quot_neg_d;
            rem_neg_q     <= rem_neg_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            result_q      <= result_d;
        end
    end

    assign o_busy   = (state_q != ST_IDLE);
    assign o_done   = (state_q == ST_DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_div_rem_seq.sv
// -----------------------------------------------------------------------------
// tb_div_rem_seq
// Self-checking bench for div_rem_seq. Expected results come from plain
// arithmetic following the RISC-V division rules; expected latency follows
// DIV_SPECIAL_FASTPATH_EN.
// -----------------------------------------------------------------------------
module tb_div_rem_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_rem_seq #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [1:0] f_op,
                                            input logic [31:0] f_a,
                                            input logic [31:0] f_b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (f_b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = f_a;
        end else if (f_op[0]) begin
            q = f_a / f_b;
            r = f_a % f_b;
        end else if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = f_a;
            sb = f_b;
            q = sa / sb;
            r = sa % sb;
        end
        return f_op[1] ? r : q;
    endfunction

    function automatic int exp_lat(input logic [1:0] f_op,
                                   input logic [31:0] f_a,
                                   input logic [31:0] f_b);
        logic special;
        special = (f_b == 32'd0) ||
                  (!f_op[0] && f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_FASTPATH_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Issue one operation from an IDLE cycle (#1 after an edge). Returns the
    // cycle index of o_done (accepting edge = cycle 0) or -1 on timeout, and
    // leaves the bench #1 after the edge that returns the DUT to IDLE.
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b,
                          output logic [31:0] res, output int lat);
        op    = t_op;
        a     = t_a;
        b     = t_b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat   = -1;
        res   = 32'hDEAD_BEEF;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [12] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01,
                                   2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
        logic [31:0] t_a  [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd7, 32'd5, 32'd5, 32'hFFFF_FFF9,
                                   32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                   32'hFFFF_FFFF};
        logic [31:0] t_b  [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                   32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] t_e  [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5,
                                   32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                                   32'hFFFF_FFF9, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            checks++;
            if (res !== t_e[i]) begin
                errors++;
                $display("FAIL directed_%0d op=%b a=%h b=%h got %h want %h",
                         i, t_op[i], t_a[i], t_b[i], res, t_e[i]);
            end
            checks++;
            if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin
                errors++;
                $display("FAIL directed_lat_%0d got %0d want %0d",
                         i, lat, exp_lat(t_op[i], t_a[i], t_b[i]));
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] res;
        logic [31:0] exp;
        int lat;
        int sel;
        for (int i = 0; i < 250; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            sel  = $urandom_range(0, 9);
            case (sel)
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                3: r_b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                4: r_b = r_b | 32'h8000_0000;
                5: r_a = r_a >> $urandom_range(0, 31);
                default: ;
            endcase
            exp = ref_div(r_op, r_a, r_b);
            run_op(r_op, r_a, r_b, res, lat);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h got %h want %h",
                         i, r_op, r_a, r_b, res, exp);
            end
            checks++;
            if (lat != exp_lat(r_op, r_a, r_b)) begin
                errors++;
                $display("FAIL random_lat_%0d got %0d want %0d",
                         i, lat, exp_lat(r_op, r_a, r_b));
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        logic [31:0] res;
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b want 1", busy); end
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                op    = 2'b00;
                a     = 32'd50;
                b     = 32'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (res !== 32'd100) begin errors++; $display("FAIL ignore_result got %h want %h", res, 32'd100); end
        checks++;
        if (lat != 34) begin errors++; $display("FAIL ignore_lat got %0d want 34", lat); end
        // Start held only during the DONE cycle must not be taken.
        op    = 2'b01;
        a     = 32'd77;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start_taken got busy=%b want 0", busy); end
        checks++;
        if (result !== 32'd100) begin errors++; $display("FAIL result_hold got %h want %h", result, 32'd100); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int lat;
        logic [31:0] res;
        op    = 2'b00;
        a     = 32'd12345;
        b     = 32'hFFFF_FFF9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL midreset_result got %h want 0", result); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midreset_done_pulses got %0d want 0", pulses); end
        run_op(2'b01, 32'd9, 32'd3, res, lat);
        checks++;
        if (res !== 32'd3) begin errors++; $display("FAIL after_reset_divu got %h want 3", res); end
        checks++;
        if (lat != 34) begin errors++; $display("FAIL after_reset_lat got %0d want 34", lat); end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        int n;
        op    = 2'b01;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        first  = -1;
        second = -1;
        n      = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (done) begin
                checks++;
                if (result !== 32'd14) begin
                    errors++;
                    $display("FAIL b2b_result got %h want %h", result, 32'd14);
                end
                if (n == 0) first = c; else second = c;
                n++;
                if (n == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (second - first != 35 || second < 0) begin
            errors++;
            $display("FAIL b2b_period got %0d want 35", second - first);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
